// File: rtl/counter_load_sched_if.sv
// Requester, completion and counter-core write/readback signals for counter_load_sched.
// The scheduler uses the slave modport; the requesters/core environment uses master.
interface counter_load_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    reqValid;
    logic [NUM_REQ-1:0]    reqReady;
    logic [NUM_REQ*32-1:0] reqCount;
    logic [NUM_REQ-1:0]    reqEn;
    logic [NUM_REQ-1:0]    reqDir;
    logic [NUM_REQ-1:0]    reqIre;
    logic                  doneValid;
    logic [ID_W-1:0]       doneId;
    logic                  doneErr;
    logic                  busy;
    logic [31:0]           counterIn;
    logic                  counterEnIn;
    logic                  counterDirIn;
    logic                  counterIreIn;
    logic                  counterWe;
    logic                  counterConfigWe;
    logic [31:0]           counterOut;
    logic                  counterDirOut;
    logic                  counterIreOut;

    modport slave (
        input  reqValid, reqCount, reqEn, reqDir, reqIre,
        input  counterOut, counterDirOut, counterIreOut,
        output reqReady, doneValid, doneId, doneErr, busy,
        output counterIn, counterEnIn, counterDirIn, counterIreIn, counterWe, counterConfigWe
    );

    modport master (
        output reqValid, reqCount, reqEn, reqDir, reqIre,
        output counterOut, counterDirOut, counterIreOut,
        input  reqReady, doneValid, doneId, doneErr, busy,
        input  counterIn, counterEnIn, counterDirIn, counterIreIn, counterWe, counterConfigWe
    );
endinterface

// File: rtl/counter_load_sched.sv
// Round-robin scheduler sharing the counter core's write port: pause, load, [verify], config, done.
// Define COUNTER_LOAD_SCHED_VERIFY_EN to insert a readback VERIFY state that drives doneErr.
module counter_load_sched #(
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                reset,
    counter_load_sched_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PAUSE  = 3'd1,
        S_LOAD   = 3'd2,
        S_VERIFY = 3'd3,
        S_CONFIG = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            en_q, en_d;
    logic            dir_q, dir_d;
    logic            ire_q, ire_d;
    logic            err_q, err_d;
    logic            grant_vld_s;
    logic [ID_W-1:0] grant_s;

`ifndef COUNTER_LOAD_SCHED_VERIFY_EN
    logic            unused_s;
    assign unused_s = ^bus.counterOut;
`endif

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Round-robin pick; scanning offsets downward lets the one nearest rr_ptr_q win.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            grant_s     = bus.reqValid[rr_index(rr_ptr_q, k)] ? rr_index(rr_ptr_q, k) : grant_s;
            grant_vld_s = grant_vld_s | bus.reqValid[rr_index(rr_ptr_q, k)];
        end
    end

    // Next-state and capture logic for the load sequence.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        dir_d    = dir_q;
        ire_d    = ire_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s) begin
                    id_d     = grant_s;
                    cnt_d    = bus.reqCount[32*int'(grant_s) +: 32];
                    en_d     = bus.reqEn[grant_s];
                    dir_d    = bus.reqDir[grant_s];
                    ire_d    = bus.reqIre[grant_s];
                    rr_ptr_d = (int'(grant_s) == NUM_REQ - 1) ? '0 : grant_s + ID_W'(1);
                    state_d  = S_PAUSE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_PAUSE:  state_d = S_LOAD;
`ifdef COUNTER_LOAD_SCHED_VERIFY_EN
            S_LOAD:   state_d = S_VERIFY;
            S_VERIFY: begin
                err_d   = (bus.counterOut != cnt_q);
                state_d = S_CONFIG;
            end
`else
            S_LOAD:   state_d = S_CONFIG;
            S_VERIFY: state_d = S_IDLE;
`endif
            S_CONFIG: state_d = S_DONE;
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode; reqReady is gated by reset so every output reads 0 while it is held.
    always_comb begin
        bus.reqReady        = '0;
        bus.doneValid       = 1'b0;
        bus.doneId          = '0;
        bus.doneErr         = 1'b0;
        bus.busy            = (state_q != S_IDLE);
        bus.counterIn       = 32'h0000_0000;
        bus.counterEnIn     = 1'b0;
        bus.counterDirIn    = 1'b0;
        bus.counterIreIn    = 1'b0;
        bus.counterWe       = 1'b0;
        bus.counterConfigWe = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s && !reset) begin
                    bus.reqReady = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_s;
                end else begin
                    bus.reqReady = '0;
                end
            end
            S_PAUSE: begin
                bus.counterConfigWe = 1'b1;
                bus.counterDirIn    = bus.counterDirOut;
                bus.counterIreIn    = bus.counterIreOut;
            end
            S_LOAD: begin
                bus.counterWe = 1'b1;
                bus.counterIn = cnt_q;
            end
            S_VERIFY: bus.counterWe = 1'b0;
            S_CONFIG: begin
                bus.counterConfigWe = 1'b1;
                bus.counterEnIn     = en_q;
                bus.counterDirIn    = dir_q;
                bus.counterIreIn    = ire_q;
            end
            S_DONE: begin
                bus.doneValid = 1'b1;
                bus.doneId    = id_q;
`ifdef COUNTER_LOAD_SCHED_VERIFY_EN
                bus.doneErr   = err_q;
`else
                bus.doneErr   = 1'b0;
`endif
            end
            default: bus.busy = 1'b1;
        endcase
    end

    // State, round-robin pointer and captured request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            cnt_q    <= 32'h0000_0000;
            en_q     <= 1'b0;
            dir_q    <= 1'b0;
            ire_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            dir_q    <= dir_d;
            ire_q    <= ire_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: doc/counter_load_sched.md
Name: counter_load_sched

Overview:
- Round-robin scheduler that shares the counter core's write port among NUM_REQ bus requesters.
- Each granted request runs a fixed sequence: pause counter, load count, apply requested config, report completion.
- Sits between requester-side masters and the counter core's register write inputs.
- Replaces direct requester access to the core's counterWe / counterConfigWe.

Parameters:
- NUM_REQ, 4, number of requesters (2..16). ID_W = clog2(NUM_REQ) is a derived localparam.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- reqValid  in  NUM_REQ  per-requester load request
- reqReady  out  NUM_REQ  one-hot accept pulse
- reqCount  in  NUM_REQ*32  per-requester count value; slice i = bits [32i+31:32i]
- reqEn  in  NUM_REQ  per-requester requested enable
- reqDir  in  NUM_REQ  per-requester requested direction
- reqIre  in  NUM_REQ  per-requester requested interrupt enable
- doneValid  out  1  completion pulse
- doneId  out  ID_W  index of the completed requester
- doneErr  out  1  readback mismatch flag, valid with doneValid
- busy  out  1  high in any state other than IDLE
- counterIn  out  32  count value to core
- counterEnIn  out  1  enable value to core
- counterDirIn  out  1  direction value to core
- counterIreIn  out  1  interrupt-enable value to core
- counterWe  out  1  core count write enable
- counterConfigWe  out  1  core config write enable
- counterOut  in  32  current core count
- counterDirOut  in  1  current core direction
- counterIreOut  in  1  current core interrupt enable

Behaviour:
- Reset, asynchronous, active-high:
  - state = IDLE, rrPtr = 0, captured registers = 0.
  - All outputs 0.
  - Reset mid-sequence abandons the operation: no doneValid, and the core is left in whatever state it was last written to.
- States: IDLE -> PAUSE -> LOAD -> [VERIFY] -> CONFIG -> DONE -> IDLE. Each non-IDLE state lasts exactly 1 cycle.
- IDLE:
  - If any reqValid is set, grant g = first set index at or after rrPtr, searching upward with wrap.
  - reqReady[g] = 1 combinationally in this cycle.
  - On the clock edge: capture reqCount/En/Dir/Ire of g and ID g; rrPtr <= (g+1) mod NUM_REQ; go to PAUSE.
  - With no reqValid set: stay in IDLE, rrPtr unchanged.
- Request handshake:
  - Requesters hold reqValid and data stable until reqReady.
  - Deasserting reqValid before a grant is legal and carries no penalty.
  - reqValid is ignored outside IDLE.
- PAUSE: counterConfigWe = 1, counterEnIn = 0, counterDirIn = counterDirOut, counterIreIn = counterIreOut. Direction and interrupt enable are preserved; only counting stops.
- LOAD: counterWe = 1, counterIn = captured count. The core may still count during the PAUSE cycle; LOAD overrides that value.
- CONFIG: counterConfigWe = 1, with counterEnIn/DirIn/IreIn = captured values.
- DONE: doneValid = 1, doneId = captured ID, doneErr = error register. Error register clears on leaving DONE.
- Outside their active states, counterWe, counterConfigWe, counterIn and the config outputs are 0.
- Latency: accept edge to doneValid high is 4 cycles without VERIFY, 5 cycles with VERIFY.
- Throughput: one operation per 5 cycles without VERIFY (6 with). A new grant is possible in the IDLE cycle after DONE.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 operations.
- Multiple simultaneous requests: exactly one reqReady bit is set; the others wait.

Optional Feature:
- Macro: COUNTER_LOAD_SCHED_VERIFY_EN.
- Defined:
  - VERIFY state is inserted between LOAD and CONFIG; the counter is paused and stable there.
  - Error register <= (counterOut != captured count).
  - doneErr reports the result of that comparison.
- Undefined:
  - LOAD goes directly to CONFIG.
  - doneErr is tied to 0.
  - counterOut is unused.

Test Plan:
- Single request, NUM_REQ=4: reqValid[2], count 0x0000_1234, En=1, Dir=1, Ire=0.
  - reqReady[2] pulses; ConfigWe in PAUSE with En=0; counterWe with 0x1234; ConfigWe with En/Dir/Ire = 1/1/0.
  - doneValid with doneId=2 four cycles after accept.
- All four requesters request at once, held until accepted.
  - Grant order 0,1,2,3; doneId sequence 0,1,2,3; one operation per 5 cycles.
- rrPtr=2 after a grant to 1, then reqValid[0] and reqValid[3] set.
  - Grant 3 first, then 0.
- Preservation: core Dir=0, Ire=1, request with Dir=1, Ire=0.
  - PAUSE drives DirIn=0, IreIn=1.
  - CONFIG drives DirIn=1, IreIn=0.
- Verify (macro defined): core stub returns 0xDEAD_BEEF while the load value is 0x10.
  - doneErr=1.
  - Matching stub gives doneErr=0 and a 5-cycle latency.
- Reset asserted during LOAD.
  - All outputs 0 immediately; no doneValid.
  - After release, a new request to 0 is granted; rrPtr is back at 0.
